// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// FSM states, opcodes, ALUOp, ALUSrcB, PCSource and the control bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ASB_REGB  = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  function automatic logic is_supported(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ) ||
           (op == OP_ADDI)  || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Moore control FSM for the multicycle MIPS datapath.
// In: clk, rst, op. Out: per-state datapath controls, illegal_op, state_dbg.
module multicycle_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  // Plain 4-bit register so unused encodings stay observable.
  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      c;
  ctrl_t      cg;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_REXEC;
          OP_BEQ:   state_d = S_BEQ;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.memread  = 1'b1;
        c.irwrite  = 1'b1;
        c.pcwrite  = 1'b1;
        c.alusrcb  = ASB_FOUR;
        c.aluop    = ALUOP_ADD;
        c.pcsource = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alusrcb = ASB_IMMSH;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ASB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_REXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = ASB_REGB;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BEQ: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = ASB_REGB;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PCSRC_ALUOUT;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
  end

  // Reset gates every strobe so nothing reaches memory, PC or regfile.
  assign cg = rst ? '0 : c;

  assign PCWrite     = cg.pcwrite;
  assign PCWriteCond = cg.pcwritecond;
  assign IorD        = cg.iord;
  assign MemRead     = cg.memread;
  assign MemWrite    = cg.memwrite;
  assign IRWrite     = cg.irwrite;
  assign MemtoReg    = cg.memtoreg;
  assign RegDst      = cg.regdst;
  assign RegWrite    = cg.regwrite;
  assign ALUSrcA     = cg.alusrca;
  assign ALUSrcB     = cg.alusrcb;
  assign ALUOp       = cg.aluop;
  assign PCSource    = cg.pcsource;

  assign illegal_op = !rst && (state_q == S_DECODE) &&
                      !is_supported(op);

  assign state_dbg = rst ? 4'(S_FETCH) : state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control.
// Scoreboard of per-cycle expected state/control vectors.
module tb_multicycle_main_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = OP_LW;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       illegal_op;
  logic [3:0] state_dbg;

  multicycle_main_control dut (
    .clk(clk), .rst(rst), .op(op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  wire [16:0] obs = {PCWrite, PCWriteCond, IorD, MemRead,
                     MemWrite, IRWrite, MemtoReg, RegDst,
                     RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, illegal_op};

  function automatic logic [16:0] exp_vec(logic [3:0] st,
                                          logic [5:0] o);
    logic pcw, pcc, iord, mr, mw, ir, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcc, iord, mr, mw, ir, m2r, rd, rw, asa, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      S_FETCH:  begin mr = 1; ir = 1; pcw = 1; asb = 2'b01; end
      S_DECODE: begin
        asb = 2'b11;
        ill = !(o inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b001000, 6'b000010});
      end
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mr = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mw = 1; iord = 1; end
      S_REXEC:  begin asa = 1; aop = 2'b10; end
      S_RWB:    begin rw = 1; rd = 1; end
      S_BEQ:    begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_ADDIWB: rw = 1;
      S_JUMP:   begin pcw = 1; pcs = 2'b10; end
      default:  ;
    endcase
    return {pcw, pcc, iord, mr, mw, ir, m2r, rd, rw, asa,
            asb, aop, pcs, ill};
  endfunction

  // op is only meaningful in DECODE/MEMADR; elsewhere drive noise.
  task automatic drive(string nm, logic [3:0] st, logic [5:0] o);
    exp_t e;
    if (st == S_DECODE || st == S_MEMADR) op = o;
    else op = 6'($urandom);
    e.nm = nm;
    e.st = st;
    e.v  = rst ? 17'h0 : exp_vec(st, o);
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive("reset", S_FETCH, OP_LW);
      op = OP_LW;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (state_dbg !== e.st || obs !== e.v) begin
        errors++;
        $display("FAIL %s cyc%0d: got st=%0d out=%h want st=%0d out=%h",
                 e.nm, i, state_dbg, obs, e.st, e.v);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_instr(string nm, logic [5:0] o,
                            input logic [3:0] seq[$]);
    exp_t e;
    foreach (seq[i]) begin
      drive(nm, seq[i], o);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (state_dbg !== e.st || obs !== e.v) begin
        errors++;
        $display("FAIL %s step%0d: got st=%0d out=%h want st=%0d out=%h",
                 e.nm, i, state_dbg, obs, e.st, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw;
    test_instr("lw", OP_LW,
      '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB});
  endtask

  task automatic test_sw;
    test_instr("sw", OP_SW,
      '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR});
  endtask

  task automatic test_rtype_beq;
    test_instr("rtype", OP_RTYPE,
      '{S_FETCH, S_DECODE, S_REXEC, S_RWB});
    test_instr("beq", OP_BEQ, '{S_FETCH, S_DECODE, S_BEQ});
  endtask

  task automatic test_addi;
    test_instr("addi", OP_ADDI,
      '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB});
  endtask

  task automatic test_j_illegal;
    test_instr("j", OP_J, '{S_FETCH, S_DECODE, S_JUMP});
    test_instr("illegal", 6'b111111, '{S_FETCH, S_DECODE});
  endtask

  task automatic test_rst_mid;
    exp_t e;
    test_instr("sw_pre", OP_SW, '{S_FETCH, S_DECODE, S_MEMADR});
    rst = 1'b1;
    drive("rst_memwr", S_FETCH, OP_SW);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (state_dbg !== e.st || obs !== e.v || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL %s: got st=%0d out=%h want st=%0d out=%h",
               e.nm, state_dbg, obs, e.st, e.v);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    test_instr("after_rst", OP_SW, '{S_FETCH, S_DECODE});
  endtask

  task automatic test_random;
    logic [5:0] ops[6] = '{OP_RTYPE, OP_LW, OP_SW,
                           OP_BEQ, OP_ADDI, OP_J};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      @(negedge clk);
      checks++;
      if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
        errors++;
        $display("FAIL rand_excl cyc%0d: MemRead=%b MemWrite=%b RegWrite=%b want no overlap",
                 i, MemRead, MemWrite, RegWrite);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype_beq();
    test_addi();
    test_j_illegal();
    test_rst_mid();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
